fetch_stage: RTL and testbench

// - Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
// - Holds the PC and drives the instruction-memory address. Captures the returned word
//   and PC+4 into IF/ID.
// - Presents opcode[5:0] directly to Control in the decode stage.
// - Supports a hazard-unit stall and a branch redirect that flushes the IF/ID register.
//

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage MIPS pipeline.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [31:0]       imemData,
    output logic [31:0]       ifidInstr,
    output logic [ADDR_W-1:0] ifidPcPlus4,
    output logic              ifidValid,
    output logic [5:0]        opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetchCount,
    output logic [31:0]       bubbleCount
`endif
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned OPC_LSB = INSTR_W - OPC_W;

    // Word alignment: the two low address bits are always cleared.
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

    // Per-cycle fetch mode derived from the stall/branch inputs.
    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_HOLD     = 2'd1;
    localparam logic [1:0] MODE_REDIRECT = 2'd2;

    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [INSTR_W-1:0] instr_q,    instr_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
    logic               valid_q,    valid_d;

    logic [1:0]         mode_c;
    logic [ADDR_W-1:0]  pc_inc_c;
    logic [ADDR_W-1:0]  target_c;

    assign pc_inc_c = pc_q + PC_STEP;
    assign target_c = branchTarget & ALIGN_MASK;

    // Branch beats stall; stall beats normal fetch.
    always_comb begin
        mode_c = MODE_RUN;
        if (branchTaken) begin
            mode_c = MODE_REDIRECT;
        end else if (stall) begin
            mode_c = MODE_HOLD;
        end
    end

    // Next-state for PC and the IF/ID register.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        case (mode_c)
            MODE_RUN: begin
                pc_d       = pc_inc_c;
                instr_d    = imemData;
                pc_plus4_d = pc_inc_c;
                valid_d    = 1'b1;
            end
            MODE_REDIRECT: begin
                pc_d       = target_c;
                instr_d    = '0;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end
            default: begin
                pc_d       = pc_q;
                instr_d    = instr_q;
                pc_plus4_d = pc_plus4_q;
                valid_d    = valid_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC_AL;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign imemAddr    = pc_q;
    assign ifidInstr   = instr_q;
    assign ifidPcPlus4 = pc_plus4_q;
    assign ifidValid   = valid_q;
    assign opcode      = instr_q[OPC_LSB +: OPC_W];

`ifdef FETCH_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] fetch_cnt_q,  fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // A cycle is either a real fetch or a bubble (stall or redirect), never both.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (mode_c == MODE_RUN) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end else begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetchCount  = fetch_cnt_q;
    assign bubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr0, imem_data0, ifid_instr0, ifid_pc4_0;
    logic        ifid_valid0;
    logic [5:0]  opcode0;
    logic [31:0] imem_addr1, imem_data1, ifid_instr1, ifid_pc4_1;
    logic        ifid_valid1;
    logic [5:0]  opcode1;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt0, bubble_cnt0, fetch_cnt1, bubble_cnt1;
`endif

    logic [31:0] mem [64];
    assign imem_data0 = mem[imem_addr0[7:2]];
    assign imem_data1 = mem[imem_addr1[7:2]];

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branchTaken(branch_taken),
        .branchTarget(branch_target), .imemAddr(imem_addr0), .imemData(imem_data0),
        .ifidInstr(ifid_instr0), .ifidPcPlus4(ifid_pc4_0), .ifidValid(ifid_valid0),
        .opcode(opcode0)
`ifdef FETCH_PERF_CNT_EN
        , .fetchCount(fetch_cnt0), .bubbleCount(bubble_cnt0)
`endif
    );

    // Misaligned reset PC near the top of the address space: exercises alignment and wrap.
    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFD)) dut_wrap (
        .clk(clk), .reset(reset), .stall(zero1), .branchTaken(zero1),
        .branchTarget(zero32), .imemAddr(imem_addr1), .imemData(imem_data1),
        .ifidInstr(ifid_instr1), .ifidPcPlus4(ifid_pc4_1), .ifidValid(ifid_valid1),
        .opcode(opcode1)
`ifdef FETCH_PERF_CNT_EN
        , .fetchCount(fetch_cnt1), .bubbleCount(bubble_cnt1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pc", imem_addr0, m_pc);
        chk("instr", ifid_instr0, m_instr);
        chk("pc4", ifid_pc4_0, m_pc4);
        chk("valid", {31'b0, ifid_valid0}, {31'b0, m_valid});
        chk("opcode", {26'b0, opcode0}, {26'b0, m_instr[31:26]});
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt0, m_fc);
        chk("bubble_cnt", bubble_cnt0, m_bc);
`endif
    endtask

    // One clock: apply inputs, advance the model by the priority rules, then compare.
    task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_fc = 32'h0; m_bc = 32'h0;
        end else if (b) begin
            m_pc = t & 32'hFFFF_FFFC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_bc = m_bc + 32'd1;
        end else if (s) begin
            m_bc = m_bc + 32'd1;
        end else begin
            m_instr = mem[m_pc[7:2]];
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_fc    = m_fc + 32'd1;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h8C01_0004;
        mem[1] = 32'h0022_1820;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fc = 0; m_bc = 0;

        step(1, 0, 0, 32'h0);
        chk("rst_addr", imem_addr0, 32'h0);
        chk("rst_opcode", {26'b0, opcode0}, 32'h0);
        chk("wrap_rst_pc", imem_addr1, 32'hFFFF_FFFC);
        chk("wrap_rst_valid", {31'b0, ifid_valid1}, 32'h0);

        step(0, 0, 0, 32'h0);
        chk("c1_addr", imem_addr0, 32'h4);
        chk("c1_instr", ifid_instr0, 32'h8C01_0004);
        chk("c1_opcode", {26'b0, opcode0}, 32'h23);
        chk("c1_pc4", ifid_pc4_0, 32'h4);
        chk("c1_valid", {31'b0, ifid_valid0}, 32'h1);
        chk("wrap_pc", imem_addr1, 32'h0);
        chk("wrap_pc4", ifid_pc4_1, 32'h0);
        chk("wrap_instr", ifid_instr1, mem[63]);

        step(0, 0, 0, 32'h0);
        chk("c2_addr", imem_addr0, 32'h8);
        chk("c2_instr", ifid_instr0, 32'h0022_1820);

        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk("stall_addr", imem_addr0, 32'h8);
        chk("stall_instr", ifid_instr0, 32'h0022_1820);
        chk("stall_valid", {31'b0, ifid_valid0}, 32'h1);
        step(0, 0, 0, 32'h0);
        chk("release_addr", imem_addr0, 32'hC);
        step(0, 0, 0, 32'h0);
        chk("pre_branch_addr", imem_addr0, 32'h10);

        step(0, 0, 1, 32'h43);
        chk("br_addr", imem_addr0, 32'h40);
        chk("br_instr", ifid_instr0, 32'h0);
        chk("br_valid", {31'b0, ifid_valid0}, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("br_target_instr", ifid_instr0, mem[16]);

        step(0, 1, 1, 32'h80);
        chk("brstall_addr", imem_addr0, 32'h80);
        chk("brstall_valid", {31'b0, ifid_valid0}, 32'h0);

        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 32'($urandom_range(0, 255)));
        end

        step(1, 1, 1, 32'h44);
        chk("midrst_addr", imem_addr0, 32'h0);
        chk("midrst_valid", {31'b0, ifid_valid0}, 32'h0);
        chk("wrap_midrst_pc", imem_addr1, 32'hFFFF_FFFC);
        chk("wrap_midrst_valid", {31'b0, ifid_valid1}, 32'h0);

        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 32'h0);
        step(0, 0, 1, 32'h20);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", fetch_cnt0, 32'd5);
        chk("perf_bubble", bubble_cnt0, 32'd3);
`endif
        chk("seq_addr", imem_addr0, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
